fft_bf_tw_stage: RTL and testbench

Pipelined radix-2 butterfly with twiddle rotation for the two-lane parallel FFT datapath. It sits directly upstream of the delay/switch commutator. It takes two complex samples per valid cycle and outputs their scaled sum on lane 0 and their scaled difference on lane 1. The lane-1 difference is multiplied by a twiddle fetched from an external synchronous ROM.

---
 rtl/fft_bf_tw_stage.sv | 106 ++++++++++
 tb/tb_fft_bf_tw_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_bf_tw_stage.sv
//==============================================================================
// Module   : fft_bf_tw_stage
// Purpose  : Two-stage radix-2 butterfly, lane-1 difference rotated by a
//            twiddle read from an external registered ROM.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fft_bf_tw_stage #(
    parameter int NB  = 8,
    parameter int NTW = 8,
    parameter int AW  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic signed [NB-1:0]  i_data_0r,
    input  logic signed [NB-1:0]  i_data_0i,
    input  logic signed [NB-1:0]  i_data_1r,
    input  logic signed [NB-1:0]  i_data_1i,
    output logic        [AW-1:0]  o_tw_addr,
    input  logic signed [NTW-1:0] i_tw_r,
    input  logic signed [NTW-1:0] i_tw_i,
    output logic                  o_valid,
    output logic signed [NB-1:0]  o_data_0r,
    output logic signed [NB-1:0]  o_data_0i,
    output logic signed [NB-1:0]  o_data_1r,
    output logic signed [NB-1:0]  o_data_1i
);

    localparam int PW = NB + NTW + 1;
    localparam logic signed [PW-1:0] RND     = PW'(2 ** (NTW - 3));
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (NB - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    // (a +/- b) / 2 with floor; bits [NB:1] of the NB+1 bit result.
    function automatic logic signed [NB-1:0] half_op(
        input logic signed [NB-1:0] a,
        input logic signed [NB-1:0] b,
        input logic                 sub
    );
        return NB'(sub ? (({a[NB-1], a} - {b[NB-1], b}) >> 1)
                       : (({a[NB-1], a} + {b[NB-1], b}) >> 1));
    endfunction

    function automatic logic signed [NB-1:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + RND) >>> (NTW - 2);
        if (r > SAT_MAX)
            return SAT_MAX[NB-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[NB-1:0];
        else
            return r[NB-1:0];
    endfunction

    logic        [AW-1:0] cnt_q, cnt_d;
    logic                 v1_q;
    logic signed [NB-1:0] s_r_q, s_i_q, d_r_q, d_i_q;
    logic signed [PW-1:0] w_dr, w_di, w_wr, w_wi, w_pr, w_pi;

    always_comb begin
        o_tw_addr = (i_valid && i_sof) ? '0 : cnt_q;
        cnt_d     = i_valid ? o_tw_addr + AW'(1) : cnt_q;
    end

    // Twiddle data arrives one cycle after its address, aligned with stage 1.
    assign w_dr = PW'(d_r_q);
    assign w_di = PW'(d_i_q);
    assign w_wr = PW'(i_tw_r);
    assign w_wi = PW'(i_tw_i);
    assign w_pr = w_dr * w_wr - w_di * w_wi;
    assign w_pi = w_dr * w_wi + w_di * w_wr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            o_valid   <= 1'b0;
            s_r_q     <= '0;
            s_i_q     <= '0;
            d_r_q     <= '0;
            d_i_q     <= '0;
            o_data_0r <= '0;
            o_data_0i <= '0;
            o_data_1r <= '0;
            o_data_1i <= '0;
        end else begin
            cnt_q     <= cnt_d;
            v1_q      <= i_valid;
            o_valid   <= v1_q;
            s_r_q     <= half_op(i_data_0r, i_data_1r, 1'b0);
            s_i_q     <= half_op(i_data_0i, i_data_1i, 1'b0);
            d_r_q     <= half_op(i_data_0r, i_data_1r, 1'b1);
            d_i_q     <= half_op(i_data_0i, i_data_1i, 1'b1);
            o_data_0r <= s_r_q;
            o_data_0i <= s_i_q;
            o_data_1r <= rnd_sat(w_pr);
            o_data_1i <= rnd_sat(w_pi);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_bf_tw_stage.sv
//==============================================================================
// Module   : tb_fft_bf_tw_stage
// Purpose  : Directed vector bench for fft_bf_tw_stage with registered ROM model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fft_bf_tw_stage;

    localparam int NB  = 8;
    localparam int NTW = 8;
    localparam int AW  = 3;
    localparam int NV  = 8;

    logic                  clk = 1'b0;
    logic                  i_rst_n;
    logic                  i_valid, i_sof;
    logic signed [NB-1:0]  i_data_0r, i_data_0i, i_data_1r, i_data_1i;
    logic        [AW-1:0]  o_tw_addr;
    logic signed [NTW-1:0] i_tw_r, i_tw_i;
    logic signed [NTW-1:0] twn_r, twn_i;
    logic                  o_valid;
    logic signed [NB-1:0]  o_data_0r, o_data_0i, o_data_1r, o_data_1i;

    int nchk;
    int nerr;

    typedef struct {
        logic signed [7:0] x0r, x0i, x1r, x1i, wr, wi, y0r, y0i, y1r, y1i;
    } vec_t;
    vec_t tbl[NV];

    logic ev[2];
    int   ey[2];

    always #5 clk = ~clk;

    // Registered ROM: the twiddle chosen with a sample is presented next cycle.
    always @(posedge clk) begin
        i_tw_r <= twn_r;
        i_tw_i <= twn_i;
    end

    fft_bf_tw_stage #(.NB(NB), .NTW(NTW), .AW(AW)) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_data_0r (i_data_0r),
        .i_data_0i (i_data_0i),
        .i_data_1r (i_data_1r),
        .i_data_1i (i_data_1i),
        .o_tw_addr (o_tw_addr),
        .i_tw_r    (i_tw_r),
        .i_tw_i    (i_tw_i),
        .o_valid   (o_valid),
        .o_data_0r (o_data_0r),
        .o_data_0i (o_data_0i),
        .o_data_1r (o_data_1r),
        .o_data_1i (o_data_1i)
    );

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " o_valid"}, int'(o_valid), 0);
        chk({tag, " y0r"}, int'(o_data_0r), 0);
        chk({tag, " y0i"}, int'(o_data_0i), 0);
        chk({tag, " y1r"}, int'(o_data_1r), 0);
        chk({tag, " y1i"}, int'(o_data_1i), 0);
    endtask

    // One cycle of a stream of real-only samples: x0=(2*val,0), x1=0, W=1.0,
    // so y0r equals val two cycles later.
    task automatic step(input logic v, input logic sof, input int eaddr, input int val);
        @(negedge clk);
        chk("stream o_valid", int'(o_valid), int'(ev[1]));
        if (ev[1])
            chk("stream y0r", int'(o_data_0r), ey[1]);
        i_valid   = v;
        i_sof     = sof;
        i_data_0r = 8'(2 * val);
        i_data_0i = '0;
        i_data_1r = '0;
        i_data_1i = '0;
        twn_r     = 8'sd64;
        twn_i     = '0;
        #1;
        chk("stream tw_addr", int'(o_tw_addr), eaddr);
        ev[1] = ev[0];
        ey[1] = ey[0];
        ev[0] = v;
        ey[0] = val;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        ev[0] = 1'b0; ev[1] = 1'b0;
        ey[0] = 0;    ey[1] = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0; i_sof = 1'b0;
        i_data_0r = '0; i_data_0i = '0; i_data_1r = '0; i_data_1i = '0;
        twn_r = '0; twn_i = '0;

        //                x0r   x0i  x1r   x1i   wr   wi    y0r y0i  y1r   y1i
        tbl[0] = '{ 40,   0,   20,   0,   64,   0,   30,  0,   10,    0};
        tbl[1] = '{ 40,   0,   20,   0,    0, -64,   30,  0,    0,  -10};
        tbl[2] = '{127,   0, -128,   0,  127,   0,   -1,  0,  127,    0};
        tbl[3] = '{-128,  0,  127,   0,  127,   0,   -1,  0, -128,    0};
        tbl[4] = '{ 10,  20,   -6,   4,   45,  45,    2, 12,    0,   11};
        tbl[5] = '{ -3,   5,   -4,  -2,   64,   0,   -4,  1,    0,    3};
        tbl[6] = '{  3,  -3,    0,   0,   32,   0,    1, -2,    1,   -1};
        tbl[7] = '{  0, 127,    0,-128,    0, 127,    0, -1, -128,    0};

        // Reset held with random activity on the inputs.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_valid   = 1'($urandom);
            i_sof     = 1'($urandom);
            i_data_0r = 8'($urandom);
            i_data_0i = 8'($urandom);
            i_data_1r = 8'($urandom);
            i_data_1i = 8'($urandom);
            twn_r     = 8'($urandom);
            twn_i     = 8'($urandom);
            #1;
            chk_zero("reset");
            chk("reset tw_addr", int'(o_tw_addr), 0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_rst_n = 1'b1;

        // Back-to-back vectors; first one has no i_sof but must use address 0.
        for (int k = 0; k < NV + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk($sformatf("vec%0d o_valid", k - 2), int'(o_valid), 1);
                chk($sformatf("vec%0d y0r", k - 2), int'(o_data_0r), int'(tbl[k-2].y0r));
                chk($sformatf("vec%0d y0i", k - 2), int'(o_data_0i), int'(tbl[k-2].y0i));
                chk($sformatf("vec%0d y1r", k - 2), int'(o_data_1r), int'(tbl[k-2].y1r));
                chk($sformatf("vec%0d y1i", k - 2), int'(o_data_1i), int'(tbl[k-2].y1i));
            end
            if (k < NV) begin
                i_valid   = 1'b1;
                i_sof     = 1'b0;
                i_data_0r = tbl[k].x0r;
                i_data_0i = tbl[k].x0i;
                i_data_1r = tbl[k].x1r;
                i_data_1i = tbl[k].x1i;
                twn_r     = tbl[k].wr;
                twn_i     = tbl[k].wi;
                #1;
                chk($sformatf("vec%0d tw_addr", k), int'(o_tw_addr), k % 8);
            end else begin
                i_valid = 1'b0;
            end
        end

        // Ten-sample frame with wrap and a gap; i_sof in the gap is ignored.
        step(1, 1, 0, 1);
        step(1, 0, 1, 2);
        step(1, 0, 2, 3);
        step(1, 0, 3, 4);
        step(1, 0, 4, 5);
        step(0, 1, 5, 0);
        step(1, 0, 5, 6);
        step(1, 0, 6, 7);
        step(1, 0, 7, 8);
        step(1, 0, 0, 9);
        step(1, 0, 1, 10);

        // New frame while cnt != 0, then restart on the sixth sample.
        step(1, 1, 0, 1);
        step(1, 0, 1, 2);
        step(1, 0, 2, 3);
        step(1, 0, 3, 4);
        step(1, 0, 4, 5);
        step(1, 1, 0, 6);
        step(1, 0, 1, 7);
        step(1, 0, 2, 8);
        step(0, 0, 3, 0);
        step(0, 0, 3, 0);

        // Reset mid-stream: two samples in flight are discarded.
        step(1, 0, 3, 11);
        step(1, 0, 4, 12);
        @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        chk_zero("midreset async");
        @(negedge clk);
        chk_zero("midreset held");
        chk("midreset tw_addr", int'(o_tw_addr), 0);
        i_rst_n = 1'b1;
        ev[0] = 1'b0; ev[1] = 1'b0;
        step(0, 0, 0, 0);
        step(1, 0, 0, 3);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

`default_nettype wire
